// File: rtl/seg_display_arbiter_if.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter_if
//   Bundle between the two display requesters and the display arbiter.
//   Both requesters (CPU debug register on port 0, picoPPU status word on
//   port 1) and the scanner-facing outputs travel together so one handle
//   wires up the whole block.
//
//   Signals
//     req0/data0  : requester 0 (high priority) request and 16-bit hex word
//     req1/data1  : requester 1 (low priority) request and 16-bit hex word
//     gnt0/gnt1   : ownership indication back to the requesters
//     disp_data   : word to the display scanner (digit3..0 = [15:12]..[3:0])
//     disp_blank  : 1 = scanner drives all anodes off
//
//   Modports
//     master : requester / environment side (drives req/data)
//     slave  : arbiter side (drives gnt/disp)
// ---------------------------------------------------------------------------
interface seg_display_arbiter_if;
    logic        req0;
    logic [15:0] data0;
    logic        req1;
    logic [15:0] data1;
    logic        gnt0;
    logic        gnt1;
    logic [15:0] disp_data;
    logic        disp_blank;

    modport master (
        output req0,
        output data0,
        output req1,
        output data1,
        input  gnt0,
        input  gnt1,
        input  disp_data,
        input  disp_blank
    );

    modport slave (
        input  req0,
        input  data0,
        input  req1,
        input  data1,
        output gnt0,
        output gnt1,
        output disp_data,
        output disp_blank
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter
//   Shares the 4-digit multiplexed 7-segment display between two requesters.
//   A grant is held for at least HOLD_CYCLES clocks so the digits never
//   flicker between sources; the display blanks after IDLE_TIMEOUT clocks
//   with no owner.
//
//   Parameters
//     HOLD_CYCLES  : minimum clocks an owner keeps the display (>= 1)
//     IDLE_TIMEOUT : clocks spent idle before the display blanks (>= 1)
//
//   Ports
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : slave side of seg_display_arbiter_if
//             (req0/data0, req1/data1 in; gnt0/gnt1, disp_data, disp_blank out)
//
//   All outputs are registered: req -> gnt takes one clock, and while a port
//   owns the display its data reaches disp_data one clock after sampling.
// ---------------------------------------------------------------------------
module seg_display_arbiter #(
    parameter int HOLD_CYCLES  = 1_000_000,
    parameter int IDLE_TIMEOUT = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_display_arbiter_if.slave  bus
);

    // A parameter value of 1 would give a zero-width counter; keep one bit.
    localparam int HOLD_W = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
    localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN0   = 2'd1,
        ST_OWN1   = 2'd2,
        ST_LINGER = 2'd3
    } state_t;

    state_t            state_q,      state_d;
    logic              owner_q,      owner_d;       // last owner, used in LINGER
    logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q,   idle_cnt_d;
    logic              gnt0_q,       gnt0_d;
    logic              gnt1_q,       gnt1_d;
    logic [15:0]       disp_data_q,  disp_data_d;
    logic              disp_blank_q, disp_blank_d;

    logic hold_done;
    logic idle_done;
    logic hold_clr;     // fresh grant: restart the minimum-hold window
    logic next_owned;   // next state is OWN0 or OWN1

    assign hold_done  = (hold_cnt_q == HOLD_LAST);
    assign idle_done  = (idle_cnt_q == IDLE_LAST);
    assign next_owned = (state_d == ST_OWN0) || (state_d == ST_OWN1);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            hold_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            disp_data_q  <= 16'h0000;
            disp_blank_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            hold_cnt_q   <= hold_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            disp_data_q  <= disp_data_d;
            disp_blank_q <= disp_blank_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        hold_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Port 0 wins a tie.
                if (bus.req0) begin
                    state_d  = ST_OWN0;
                    hold_clr = 1'b1;
                end else if (bus.req1) begin
                    state_d  = ST_OWN1;
                    hold_clr = 1'b1;
                end
            end

            ST_OWN0: begin
                // Port 1 never preempts; it only gets in once port 0 lets go.
                if (!bus.req0) begin
                    if (!hold_done) begin
                        state_d = ST_LINGER;
                    end else if (bus.req1) begin
                        state_d  = ST_OWN1;
                        hold_clr = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_OWN1: begin
                if (bus.req0 && hold_done) begin
                    // Preemption: gnt1 falls and gnt0 rises on the same edge.
                    state_d  = ST_OWN0;
                    hold_clr = 1'b1;
                end else if (!bus.req1) begin
                    // req0 is necessarily low when hold_done here, so the
                    // only place left to go is IDLE.
                    state_d = hold_done ? ST_IDLE : ST_LINGER;
                end
            end

            ST_LINGER: begin
                if (hold_done) begin
                    // Window expired: arbitrate right away, no IDLE dwell.
                    if (bus.req0) begin
                        state_d  = ST_OWN0;
                        hold_clr = 1'b1;
                    end else if (bus.req1) begin
                        state_d  = ST_OWN1;
                        hold_clr = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!owner_q && bus.req0) begin
                    // Same owner returning: the hold window keeps running.
                    state_d = ST_OWN0;
                end else if (owner_q && bus.req1) begin
                    state_d = ST_OWN1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_OWN0) begin
            owner_d = 1'b0;
        end else if (state_d == ST_OWN1) begin
            owner_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Output / counter logic
    // -----------------------------------------------------------------------
    always_comb begin
        gnt0_d       = (state_d == ST_OWN0);
        gnt1_d       = (state_d == ST_OWN1);
        disp_data_d  = disp_data_q;
        disp_blank_d = disp_blank_q;
        hold_cnt_d   = hold_cnt_q;
        idle_cnt_d   = idle_cnt_q;

        // Data follows the owner that held the display during this cycle,
        // so a new owner's word appears one clock after its grant.
        if (state_q == ST_OWN0) begin
            disp_data_d = bus.data0;
        end else if (state_q == ST_OWN1) begin
            disp_data_d = bus.data1;
        end

        // Hold window runs through OWNx and LINGER and sticks at its end.
        if (hold_clr) begin
            hold_cnt_d = '0;
        end else if ((state_q != ST_IDLE) && !hold_done) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end

        if (next_owned) begin
            idle_cnt_d   = '0;
            disp_blank_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (idle_done) begin
                disp_blank_d = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    assign bus.gnt0       = gnt0_q;
    assign bus.gnt1       = gnt1_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.disp_blank = disp_blank_q;

endmodule
